fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Program-counter and fetch controller for the 16-bit pmips core. Drives iaddr into the
//  combinational instruction memory and latches idata into the instruction register (ir)
//  for decode. Handles stall, taken-branch redirect with squash, halt, free-run/single-step
//  modes for board debug, and an issued-instruction counter.
// PARAMETERS
//  AW        16       PC / iaddr width in bits (byte address, instructions 2-byte aligned)
//  IW        16       instruction width
//  RESET_PC  16'h0000 PC value loaded on reset
// PORTS
//  clock      in   1   system clock; all state changes on rising edge
//  reset      in   1   asynchronous, active-low reset (0 = reset)
//  run_mode   in   1   1 = free run, 0 = single-step
//  step       in   1   single-step request (level from debounced button; edge-detected here)
//  stall      in   1   datapath holds current ir this cycle
//  halt_req   in   1   stop fetching permanently (until reset)
//  br_take    in   1   instruction in ir is a taken branch
//  br_target  in   AW  branch target byte address
//  idata      in   IW  instruction word from memory at iaddr (same cycle)
//  iaddr      out  AW  fetch address = pc
//  ir         out  IW  instruction register
//  ir_valid   out  1   ir holds an instruction to execute this cycle
//  pc_plus2   out  AW  address of instruction following ir (for link/branch calc)
//  icount     out  16  count of instructions loaded into ir
//  state      out  2   00 IDLE, 01 FETCH, 10 WAIT_STEP, 11 HALTED
// BEHAVIOUR
//  - Reset (async): pc=RESET_PC, ir=0, ir_valid=0, pc_plus2=RESET_PC, icount=0,
//    step_q=0, state=IDLE. Outputs settle immediately on reset assertion.
//  - iaddr = {pc[AW-1:1],1'b0} combinationally; memory has zero latency; one fetch per cycle.
//  - IDLE: first edge after reset release -> FETCH if run_mode=1, else WAIT_STEP; no load.
//  - FETCH, per edge, priority stall > halt_req > br_take > sequential:
//    stall=1: hold pc, ir, ir_valid, pc_plus2, icount; br_take/halt_req ignored.
//    halt_req=1: ir_valid<=0, pc held, state<=HALTED.
//    br_take=1 and ir_valid=1: squash; ir_valid<=0, pc<={br_target[AW-1:1],0}, icount held.
//    else: ir<=idata, ir_valid<=1, pc_plus2<=pc+2, pc<=pc+2, icount<=icount+1.
//    After a non-stalled edge, state<=WAIT_STEP if run_mode=0, else stays FETCH.
//  - Branch penalty: exactly one bubble cycle (ir_valid=0) after a taken branch.
//  - WAIT_STEP: ir_valid<=0 every edge unless a step edge (step=1, step_q=0) occurs;
//    then load as in sequential FETCH (ir_valid=1 for exactly one cycle).
//    br_take with ir_valid=1 in this state: pc<=target, no squash needed.
//    run_mode=1 -> FETCH; halt_req -> HALTED. step_q<=step every edge.
//  - HALTED: ir_valid=0, pc/ir/icount frozen; exits only via reset.
//  - Arithmetic: pc+2 wraps mod 2^AW (16'hFFFE -> 16'h0000); icount wraps 16'hFFFF -> 0.
//  - br_target bit 0 is ignored (forced to 0). br_take with ir_valid=0 is ignored.
//  - Reset mid-operation: async return to reset values regardless of state or stall.
// TESTING
//  1 Reset low then release, run_mode=1 -> iaddr 0000; ir_valid 0 first cycle;
//    then iaddr 0002,0004,0006 on successive edges, ir=word@0,2,4; icount=1,2,3.
//  2 ir at 0008 with br_take=1, br_target=0003 -> next ir_valid=0, iaddr=0002,
//    next ir=word@0002, icount unchanged across the squash.
//  3 stall=1 for 3 cycles while br_take=1 and halt_req=1 -> pc, ir, ir_valid, icount
//    unchanged; after stall drops, halt_req takes effect: state=HALTED, ir_valid=0.
//  4 RESET_PC=16'hFFFC, free run -> iaddr FFFC, FFFE, 0000, 0002; icount preset FFFF
//    (forced) rolls to 0000 on next load.
//  5 run_mode=0: held step high 5 cycles -> exactly one ir_valid pulse, pc +2;
//    second press -> second pulse; run_mode=1 -> continuous fetch resumes.
//  6 reset asserted mid-stall in FETCH -> same cycle ir_valid=0, iaddr=RESET_PC,
//    state=IDLE; normal sequence after release.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller for the 16-bit pmips core.
// Supplies iaddr to a zero-latency instruction memory and latches idata into ir.
module fetch_sequencer #(
    parameter int unsigned   AW       = 16,
    parameter int unsigned   IW       = 16,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          run_mode,
    input  logic          step,
    input  logic          stall,
    input  logic          halt_req,
    input  logic          br_take,
    input  logic [AW-1:0] br_target,
    input  logic [IW-1:0] idata,
    output logic [AW-1:0] iaddr,
    output logic [IW-1:0] ir,
    output logic          ir_valid,
    output logic [AW-1:0] pc_plus2,
    output logic [15:0]   icount,
    output logic [1:0]    state
);

    localparam int unsigned CW = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        FETCH     = 2'b01,
        WAIT_STEP = 2'b10,
        HALTED    = 2'b11
    } state_t;

    state_t        st;
    logic [AW-1:0] pc;
    logic          step_q;

    logic [AW-1:0] pc_inc;
    logic [AW-1:0] br_addr;
    logic          step_edge;
    logic          br_live;
    logic          unused_br_lsb;

    assign pc_inc        = pc + AW'(2);
    assign br_addr       = {br_target[AW-1:1], 1'b0};
    assign step_edge     = step & ~step_q;
    assign br_live       = br_take & ir_valid;
    assign unused_br_lsb = br_target[0];

    assign iaddr = {pc[AW-1:1], 1'b0};
    assign state = st;

    // Sequencer: stall > halt_req > taken branch > load, in both FETCH and WAIT_STEP
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st       <= IDLE;
            pc       <= RESET_PC;
            ir       <= '0;
            ir_valid <= 1'b0;
            pc_plus2 <= RESET_PC;
            icount   <= '0;
            step_q   <= 1'b0;
        end else begin
            step_q <= step;
            case (st)
                IDLE: begin
                    st <= run_mode ? FETCH : WAIT_STEP;
                end

                FETCH: begin
                    if (stall) begin
                        st <= FETCH;
                    end else if (halt_req) begin
                        ir_valid <= 1'b0;
                        st       <= HALTED;
                    end else begin
                        if (br_live) begin
                            // Squash the fetch in flight; one bubble before the target loads
                            ir_valid <= 1'b0;
                            pc       <= br_addr;
                        end else begin
                            ir       <= idata;
                            ir_valid <= 1'b1;
                            pc_plus2 <= pc_inc;
                            pc       <= pc_inc;
                            icount   <= icount + CW'(1);
                        end
                        st <= run_mode ? FETCH : WAIT_STEP;
                    end
                end

                WAIT_STEP: begin
                    if (stall) begin
                        st <= WAIT_STEP;
                    end else if (halt_req) begin
                        ir_valid <= 1'b0;
                        st       <= HALTED;
                    end else begin
                        if (br_live) begin
                            ir_valid <= 1'b0;
                            pc       <= br_addr;
                        end else if (step_edge) begin
                            ir       <= idata;
                            ir_valid <= 1'b1;
                            pc_plus2 <= pc_inc;
                            pc       <= pc_inc;
                            icount   <= icount + CW'(1);
                        end else begin
                            ir_valid <= 1'b0;
                        end
                        st <= run_mode ? FETCH : WAIT_STEP;
                    end
                end

                HALTED: begin
                    ir_valid <= 1'b0;
                end

                default: begin
                    st <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: one instance at RESET_PC 0000 and one at FFFC
// share all inputs; each sees its own combinational instruction memory.
module tb_fetch_sequencer;

    logic        clock;
    logic        reset;
    logic        run_mode;
    logic        step;
    logic        stall;
    logic        halt_req;
    logic        br_take;
    logic [15:0] br_target;

    logic [15:0] idata0, iaddr0, ir0, pc_plus2_0, icount0;
    logic        ir_valid0;
    logic [1:0]  state0;
    logic [15:0] idata1, iaddr1, ir1, pc_plus2_1, icount1;
    logic        ir_valid1;
    logic [1:0]  state1;

    int n_cmp = 0;
    int n_err = 0;
    int pulses;

    function automatic logic [15:0] word(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    assign idata0 = word(iaddr0);
    assign idata1 = word(iaddr1);

    fetch_sequencer #(.AW(16), .IW(16), .RESET_PC(16'h0000)) dut0 (
        .clock(clock), .reset(reset), .run_mode(run_mode), .step(step),
        .stall(stall), .halt_req(halt_req), .br_take(br_take), .br_target(br_target),
        .idata(idata0), .iaddr(iaddr0), .ir(ir0), .ir_valid(ir_valid0),
        .pc_plus2(pc_plus2_0), .icount(icount0), .state(state0)
    );

    fetch_sequencer #(.AW(16), .IW(16), .RESET_PC(16'hFFFC)) dut1 (
        .clock(clock), .reset(reset), .run_mode(run_mode), .step(step),
        .stall(stall), .halt_req(halt_req), .br_take(br_take), .br_target(br_target),
        .idata(idata1), .iaddr(iaddr1), .ir(ir1), .ir_valid(ir_valid1),
        .pc_plus2(pc_plus2_1), .icount(icount1), .state(state1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; run_mode = 1'b1; step = 1'b0; stall = 1'b0;
        halt_req = 1'b0; br_take = 1'b0; br_target = 16'h0000;

        // Reset values
        tick(); tick();
        check("rst_iaddr",    iaddr0, 16'h0000);
        check("rst_ir",       ir0, 16'h0000);
        check("rst_valid",    16'(ir_valid0), 16'h0000);
        check("rst_pcp2",     pc_plus2_0, 16'h0000);
        check("rst_icount",   icount0, 16'h0000);
        check("rst_state",    16'(state0), 16'h0000);
        check("rst_iaddr_hi", iaddr1, 16'hFFFC);

        // Free run sequential fetch
        reset = 1'b1;
        tick();
        check("idle_state", 16'(state0), 16'h0001);
        check("idle_valid", 16'(ir_valid0), 16'h0000);
        check("idle_iaddr", iaddr0, 16'h0000);
        check("hi_iaddr0",  iaddr1, 16'hFFFC);
        tick();
        check("seq1_ir",     ir0, word(16'h0000));
        check("seq1_valid",  16'(ir_valid0), 16'h0001);
        check("seq1_iaddr",  iaddr0, 16'h0002);
        check("seq1_icount", icount0, 16'h0001);
        check("seq1_pcp2",   pc_plus2_0, 16'h0002);
        check("hi_iaddr1",   iaddr1, 16'hFFFE);
        check("hi_ir1",      ir1, word(16'hFFFC));
        tick();
        check("seq2_ir",     ir0, word(16'h0002));
        check("seq2_iaddr",  iaddr0, 16'h0004);
        check("seq2_icount", icount0, 16'h0002);
        check("hi_iaddr2",   iaddr1, 16'h0000);
        tick();
        check("seq3_ir",     ir0, word(16'h0004));
        check("seq3_iaddr",  iaddr0, 16'h0006);
        check("seq3_icount", icount0, 16'h0003);
        check("hi_iaddr3",   iaddr1, 16'h0002);
        check("hi_ir3",      ir1, word(16'h0000));
        tick(); tick();
        check("pre_br_ir",     ir0, word(16'h0008));
        check("pre_br_icount", icount0, 16'h0005);

        // Taken branch with odd target: squash, one bubble, then target word
        br_take = 1'b1; br_target = 16'h0003;
        tick();
        br_take = 1'b0;
        check("br_valid",  16'(ir_valid0), 16'h0000);
        check("br_iaddr",  iaddr0, 16'h0002);
        check("br_icount", icount0, 16'h0005);
        tick();
        check("br_tgt_ir",     ir0, word(16'h0002));
        check("br_tgt_valid",  16'(ir_valid0), 16'h0001);
        check("br_tgt_icount", icount0, 16'h0006);
        check("br_tgt_pcp2",   pc_plus2_0, 16'h0004);

        // Stall overrides branch and halt
        stall = 1'b1; br_take = 1'b1; halt_req = 1'b1; br_target = 16'h0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_iaddr",  iaddr0, 16'h0004);
            check("stall_ir",     ir0, word(16'h0002));
            check("stall_valid",  16'(ir_valid0), 16'h0001);
            check("stall_icount", icount0, 16'h0006);
        end
        stall = 1'b0;
        tick();
        check("halt_state", 16'(state0), 16'h0003);
        check("halt_valid", 16'(ir_valid0), 16'h0000);
        check("halt_iaddr", iaddr0, 16'h0004);
        br_take = 1'b0; halt_req = 1'b0;
        tick(); tick();
        check("halted_state",  16'(state0), 16'h0003);
        check("halted_iaddr",  iaddr0, 16'h0004);
        check("halted_icount", icount0, 16'h0006);

        // Single-step mode
        reset = 1'b0; run_mode = 1'b0;
        #1;
        check("rst2_state", 16'(state0), 16'h0000);
        check("rst2_iaddr", iaddr0, 16'h0000);
        reset = 1'b1;
        tick();
        check("ws_state", 16'(state0), 16'h0002);
        check("ws_valid", 16'(ir_valid0), 16'h0000);
        step = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ir_valid0) pulses++;
        end
        check("step1_pulses", 16'(pulses), 16'h0001);
        check("step1_iaddr",  iaddr0, 16'h0002);
        check("step1_ir",     ir0, word(16'h0000));
        check("step1_icount", icount0, 16'h0001);
        step = 1'b0;
        tick();
        step = 1'b1;
        tick();
        check("step2_valid",  16'(ir_valid0), 16'h0001);
        check("step2_ir",     ir0, word(16'h0002));
        check("step2_iaddr",  iaddr0, 16'h0004);
        check("step2_icount", icount0, 16'h0002);
        tick();
        check("step2_drop", 16'(ir_valid0), 16'h0000);
        step = 1'b0; run_mode = 1'b1;
        tick();
        check("resume_state", 16'(state0), 16'h0001);
        tick();
        check("resume_ir",     ir0, word(16'h0004));
        check("resume_iaddr",  iaddr0, 16'h0006);
        check("resume_icount", icount0, 16'h0003);
        tick();
        check("resume2_iaddr", iaddr0, 16'h0008);
        check("resume2_valid", 16'(ir_valid0), 16'h0001);

        // Asynchronous reset in the middle of a stall
        stall = 1'b1;
        tick();
        check("mid_stall_iaddr", iaddr0, 16'h0008);
        #2;
        reset = 1'b0;
        #1;
        check("async_valid",  16'(ir_valid0), 16'h0000);
        check("async_iaddr",  iaddr0, 16'h0000);
        check("async_state",  16'(state0), 16'h0000);
        check("async_icount", icount0, 16'h0000);
        check("async_hi",     iaddr1, 16'hFFFC);
        stall = 1'b0;
        #1;
        reset = 1'b1;
        tick();
        check("post_idle_iaddr", iaddr0, 16'h0000);
        tick();
        check("post_ir",     ir0, word(16'h0000));
        check("post_iaddr",  iaddr0, 16'h0002);
        check("post_icount", icount0, 16'h0001);
        check("post_hi",     iaddr1, 16'hFFFE);

        // Counter and PC wrap on the high-reset instance
        repeat (65534) tick();
        check("wrap_icount_max", icount1, 16'hFFFF);
        check("wrap_iaddr_pre",  iaddr1, 16'hFFFA);
        tick();
        check("wrap_icount_zero", icount1, 16'h0000);
        check("wrap_iaddr_post",  iaddr1, 16'hFFFC);
        check("wrap_pcp2",        pc_plus2_1, 16'hFFFC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
